fu_complete_arb: RTL and testbench

//  Complete-stage arbiter directly downstream of the FU array. Catches each FU's finished

---
 rtl/fu_complete_arb.sv | 125 ++++++++++++
 tb/tb_fu_complete_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_complete_arb.sv
// Complete-stage arbiter: per-FU one-entry hold registers, round-robin grant of up to NUM_CDB
// results per cycle onto registered CDB slots. Optional live-input bypass via CDB_BYPASS_EN.
module fu_complete_arb #(
    parameter int unsigned NUM_FU  = 8,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned PR_W    = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_FU-1:0]         fu_done,
    input  logic [NUM_FU*PR_W-1:0]    fu_T_idx,
    input  logic [NUM_FU*XLEN-1:0]    fu_result,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*PR_W-1:0]   cdb_T_idx,
    output logic [NUM_CDB*XLEN-1:0]   cdb_result
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]  hold_valid;
    logic [PR_W-1:0]    hold_tag  [NUM_FU];
    logic [XLEN-1:0]    hold_data [NUM_FU];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;

    logic [NUM_FU-1:0]  cand;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  live_grant;
    logic [NUM_FU-1:0]  capture;
    logic [NUM_CDB-1:0] slot_used;
    logic [PR_W-1:0]    slot_tag  [NUM_CDB];
    logic [XLEN-1:0]    slot_data [NUM_CDB];

`ifdef CDB_BYPASS_EN
    assign cand = hold_valid | (fu_done & {NUM_FU{~squash}});
`else
    assign cand = hold_valid;
`endif

    // Scan from rr_ptr; the n-th candidate found drives slot n. Held entries win over live input.
    always_comb begin
        int idx;
        int cnt;
        idx        = 0;
        cnt        = 0;
        grant      = '0;
        live_grant = '0;
        slot_used  = '0;
        next_ptr   = rr_ptr;
        for (int n = 0; n < int'(NUM_CDB); n++) begin
            slot_tag[n]  = '0;
            slot_data[n] = '0;
        end
        for (int k = 0; k < int'(NUM_FU); k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_FU)) begin
                idx = idx - int'(NUM_FU);
            end
            if (cand[idx] && (cnt < int'(NUM_CDB))) begin
                grant[idx]     = 1'b1;
                slot_used[cnt] = 1'b1;
                if (hold_valid[idx]) begin
                    slot_tag[cnt]  = hold_tag[idx];
                    slot_data[cnt] = hold_data[idx];
                end else begin
                    live_grant[idx] = 1'b1;
                    slot_tag[cnt]   = fu_T_idx[idx*PR_W +: PR_W];
                    slot_data[cnt]  = fu_result[idx*XLEN +: XLEN];
                end
                next_ptr = (idx == int'(NUM_FU) - 1) ? '0 : PTR_W'(idx + 1);
                cnt      = cnt + 1;
            end
        end
    end

    always_comb begin
        fu_ready = squash ? '1 : (~hold_valid | grant);
        // A bypassed live result is consumed straight to the CDB and never enters hold.
        capture  = fu_done & fu_ready & ~live_grant & {NUM_FU{~squash}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            cdb_valid  <= '0;
            cdb_T_idx  <= '0;
            cdb_result <= '0;
        end else if (squash) begin
            hold_valid <= '0;
            cdb_valid  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (capture[i]) begin
                    hold_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            for (int n = 0; n < int'(NUM_CDB); n++) begin
                cdb_valid[n] <= slot_used[n];
                if (slot_used[n]) begin
                    cdb_T_idx[n*PR_W +: PR_W]  <= slot_tag[n];
                    cdb_result[n*XLEN +: XLEN] <= slot_data[n];
                end
            end
            if (|grant) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (capture[i]) begin
                hold_tag[i]  <= fu_T_idx[i*PR_W +: PR_W];
                hold_data[i] <= fu_result[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_fu_complete_arb.sv
// Directed bench for fu_complete_arb: vector table for single/contention/wrap/squash cases,
// plus backpressure scoreboard, reset-under-load and (with CDB_BYPASS_EN) bypass sequences.
module tb_fu_complete_arb;

    localparam int unsigned NUM_FU  = 8;
    localparam int unsigned NUM_CDB = 2;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned PR_W    = 6;

    logic                    clock;
    logic                    reset;
    logic                    squash;
    logic [NUM_FU-1:0]       fu_done;
    logic [NUM_FU*PR_W-1:0]  fu_T_idx;
    logic [NUM_FU*XLEN-1:0]  fu_result;
    logic [NUM_FU-1:0]       fu_ready;
    logic [NUM_CDB-1:0]      cdb_valid;
    logic [NUM_CDB*PR_W-1:0] cdb_T_idx;
    logic [NUM_CDB*XLEN-1:0] cdb_result;

    int n_cmp = 0;
    int n_bad = 0;

    fu_complete_arb #(
        .NUM_FU  (NUM_FU),
        .NUM_CDB (NUM_CDB),
        .XLEN    (XLEN),
        .PR_W    (PR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_done    (fu_done),
        .fu_T_idx   (fu_T_idx),
        .fu_result  (fu_result),
        .fu_ready   (fu_ready),
        .cdb_valid  (cdb_valid),
        .cdb_T_idx  (cdb_T_idx),
        .cdb_result (cdb_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        sq;
        logic [7:0]  done;
        logic [5:0]  tbase;
        logic [63:0] rbase;
        logic [7:0]  ready;
        logic [1:0]  valid;
        logic [5:0]  tag0;
        logic [63:0] res0;
        logic [5:0]  tag1;
        logic [63:0] res1;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic sq, input logic [7:0] done,
                                input logic [5:0] tbase, input logic [63:0] rbase,
                                input logic [7:0] ready, input logic [1:0] valid,
                                input logic [5:0] tag0, input logic [63:0] res0,
                                input logic [5:0] tag1, input logic [63:0] res1);
        vec_t v;
        v.rst = rst; v.sq = sq; v.done = done; v.tbase = tbase; v.rbase = rbase;
        v.ready = ready; v.valid = valid;
        v.tag0 = tag0; v.res0 = res0; v.tag1 = tag1; v.res1 = res1;
        return v;
    endfunction

    // FU i gets tag tbase+i and value rbase+i.
    task automatic drive(input logic rst, input logic sq, input logic [7:0] done,
                         input logic [5:0] tbase, input logic [63:0] rbase);
        reset   = rst;
        squash  = sq;
        fu_done = done;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            fu_T_idx[i*PR_W +: PR_W]  = tbase + 6'(i);
            fu_result[i*XLEN +: XLEN] = rbase + 64'(i);
        end
    endtask

    task automatic step(input vec_t v, input int r);
        drive(v.rst, v.sq, v.done, v.tbase, v.rbase);
        #2;
        chk($sformatf("row%0d fu_ready", r), 64'(fu_ready), 64'(v.ready));
        @(posedge clock);
        #1;
        chk($sformatf("row%0d cdb_valid", r), 64'(cdb_valid), 64'(v.valid));
        if (v.valid[0]) begin
            chk($sformatf("row%0d tag0", r), 64'(cdb_T_idx[5:0]), 64'(v.tag0));
            chk($sformatf("row%0d res0", r), cdb_result[63:0], v.res0);
        end
        if (v.valid[1]) begin
            chk($sformatf("row%0d tag1", r), 64'(cdb_T_idx[11:6]), 64'(v.tag1));
            chk($sformatf("row%0d res1", r), cdb_result[127:64], v.res1);
        end
    endtask

    vec_t vecs[20];
    int   seq_in  [NUM_FU];
    int   seq_out [NUM_FU];

    initial begin
        // rst sq done tbase rbase | ready valid tag0 res0 tag1 res1
        vecs[0]  = mk(0, 0, 8'h08, 6'h12, 64'hDEAD_BEEE_FFFF_FFFE, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b01,
                      6'h15, 64'hDEAD_BEEF_0000_0001, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 8'hFF, 6'h00, 64'h100, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'h03, 2'b11, 6'h00, 64'h100, 6'h01, 64'h101);
        vecs[6]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'h0F, 2'b11, 6'h02, 64'h102, 6'h03, 64'h103);
        vecs[7]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'h3F, 2'b11, 6'h04, 64'h104, 6'h05, 64'h105);
        vecs[8]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b11, 6'h06, 64'h106, 6'h07, 64'h107);
        vecs[9]  = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 8'h40, 6'h20, 64'h200, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b01, 6'h26, 64'h206, 0, 0);
        vecs[12] = mk(0, 0, 8'hC1, 6'h30, 64'h300, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hBF, 2'b11, 6'h37, 64'h307, 6'h30, 64'h300);
        vecs[14] = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b01, 6'h36, 64'h306, 0, 0);
        vecs[15] = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 8'h0F, 6'h08, 64'h400, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[17] = mk(0, 1, 8'h04, 6'h10, 64'h500, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b00, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 8'h00, 6'h00, 64'h0, 8'hFF, 2'b00, 0, 0, 0, 0);

        drive(1'b1, 1'b0, 8'h00, 6'h00, 64'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #2;
        chk("reset fu_ready", 64'(fu_ready), 64'hFF);
        chk("reset cdb_valid", 64'(cdb_valid), 64'h0);
        chk("reset cdb_T_idx", 64'(cdb_T_idx), 64'h0);
        chk("reset cdb_result0", cdb_result[63:0], 64'h0);
        chk("reset cdb_result1", cdb_result[127:64], 64'h0);
        @(posedge clock);
        #1;

`ifndef CDB_BYPASS_EN
        for (int r = 0; r < 20; r++) begin
            step(vecs[r], r);
        end
`else
        // Live input goes straight to slot 0 in one edge and is not also held.
        drive(1'b0, 1'b0, 8'h00, 6'h00, 64'h0);
        fu_done = 8'h02;
        fu_T_idx[PR_W +: PR_W] = 6'h2A;
        fu_result[XLEN +: XLEN] = 64'h1234_5678_9ABC_DEF0;
        #2;
        chk("bypass fu_ready", 64'(fu_ready), 64'hFF);
        @(posedge clock);
        #1;
        chk("bypass cdb_valid", 64'(cdb_valid), 64'h1);
        chk("bypass tag0", 64'(cdb_T_idx[5:0]), 64'h2A);
        chk("bypass res0", cdb_result[63:0], 64'h1234_5678_9ABC_DEF0);
        fu_done = 8'h00;
        #2;
        chk("bypass hold empty", 64'(fu_ready), 64'hFF);
        @(posedge clock);
        #1;
        chk("bypass no repeat", 64'(cdb_valid), 64'h0);
`endif

        // Backpressure: FUs 0-5 all busy; each stream must emerge complete and in order.
        drive(1'b1, 1'b0, 8'h00, 6'h00, 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            seq_in[i]  = 0;
            seq_out[i] = 0;
        end
        for (int c = 0; c < 20; c++) begin
            logic [NUM_FU-1:0] took;
            fu_done = (c < 6) ? 8'h3F : 8'h00;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                fu_T_idx[i*PR_W +: PR_W]  = {3'(i), 3'(seq_in[i])};
                fu_result[i*XLEN +: XLEN] = 64'hF000_0000_0000_0000 | 64'(i * 256 + seq_in[i]);
            end
            #2;
            took = fu_done & fu_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (took[i]) seq_in[i]++;
            end
            for (int n = 0; n < int'(NUM_CDB); n++) begin
                if (cdb_valid[n]) begin
                    logic [5:0] t;
                    int         f;
                    t = cdb_T_idx[n*PR_W +: PR_W];
                    f = int'(t[5:3]);
                    chk($sformatf("bp fu%0d order", f), 64'(t[2:0]), 64'(seq_out[f]));
                    chk($sformatf("bp fu%0d value", f), cdb_result[n*XLEN +: XLEN],
                        64'hF000_0000_0000_0000 | 64'(f * 256 + seq_out[f]));
                    seq_out[f]++;
                end
            end
        end
        for (int i = 0; i < int'(NUM_FU); i++) begin
            chk($sformatf("bp fu%0d count", i), 64'(seq_out[i]), 64'(seq_in[i]));
        end
        chk("bp fu5 progressed", 64'(seq_in[5] > 0), 64'h1);

        // Reset under load drops every pending result.
        drive(1'b0, 1'b0, 8'hFF, 6'h00, 64'h900);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst-load cdb_valid", 64'(cdb_valid), 64'h0);
        drive(1'b0, 1'b0, 8'h00, 6'h00, 64'h0);
        #2;
        chk("rst-load fu_ready", 64'(fu_ready), 64'hFF);
        @(posedge clock);
        #1;
        chk("rst-load drained", 64'(cdb_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
